// File: rtl/btn_pkg.sv
// Shared types and default timing constants for the push-button conditioner.
package btn_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DEB_PRESS,
        HELD,
        DEB_RELEASE
    } btn_state_t;

    // 10 ms debounce, 500 ms to first repeat, 200 ms repeat period at 100 MHz
    localparam int DEBOUNCE_CYCLES_DEF = 1000000;
    localparam int REPEAT_DELAY_DEF    = 50000000;
    localparam int REPEAT_PERIOD_DEF   = 20000000;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer that brings the asynchronous button level into the clk domain.
module sync_2ff (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    // NOTE: sequential state uses non-blocking assignments so both flops sample before either updates.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/button_conditioner.sv
// Debounces a raw button into a level plus press/release strobes.
// Optional auto-repeat of the press strobe is enabled by defining BTN_AUTOREPEAT_EN.
module button_conditioner
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int REPEAT_DELAY    = REPEAT_DELAY_DEF,
    parameter int REPEAT_PERIOD   = REPEAT_PERIOD_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_in,
    output logic btn_level,
    output logic btn_pulse,
    output logic btn_release
);

    localparam int CW = $clog2(max3(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD)) + 1;
    localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE_CYCLES - 1);

    generate
        if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
            $error("button_conditioner: DEBOUNCE_CYCLES must be at least 2");
        end
    endgenerate

    btn_state_t    state;
    logic [CW-1:0] deb_cnt;
    logic          btn_sync;

    sync_2ff u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (btn_in),
        .q     (btn_sync)
    );

`ifdef BTN_AUTOREPEAT_EN
    localparam logic [CW-1:0] REP_DELAY_LAST  = CW'(REPEAT_DELAY - 1);
    localparam logic [CW-1:0] REP_PERIOD_LAST = CW'(REPEAT_PERIOD - 1);

    logic [CW-1:0] rep_cnt;
    logic          rep_first;
    logic          rep_active;
    logic          rep_fire;

    // Repeats keep running through a release bounce; only a fresh press restarts them.
    assign rep_active = (state == HELD) || (state == DEB_RELEASE);
    assign rep_fire   = rep_active &&
                        (rep_cnt == (rep_first ? REP_DELAY_LAST : REP_PERIOD_LAST));
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            deb_cnt     <= '0;
            btn_level   <= 1'b0;
            btn_pulse   <= 1'b0;
            btn_release <= 1'b0;
`ifdef BTN_AUTOREPEAT_EN
            rep_cnt     <= '0;
            rep_first   <= 1'b1;
`endif
        end else begin
            // NOTE: strobes default low every cycle so each one lasts exactly one clock.
            btn_pulse   <= 1'b0;
            btn_release <= 1'b0;
`ifdef BTN_AUTOREPEAT_EN
            if (rep_fire) begin
                rep_cnt   <= '0;
                rep_first <= 1'b0;
                btn_pulse <= 1'b1;
            end else if (rep_active) begin
                rep_cnt <= rep_cnt + 1'b1;
            end
`endif
            case (state)
                IDLE: begin
                    if (btn_sync) begin
                        state   <= DEB_PRESS;
                        deb_cnt <= '0;
                    end
                end
                DEB_PRESS: begin
                    if (!btn_sync) begin
                        state   <= IDLE;
                        deb_cnt <= '0;
                    end else if (deb_cnt == DEB_LAST) begin
                        state     <= HELD;
                        btn_level <= 1'b1;
                        btn_pulse <= 1'b1;
`ifdef BTN_AUTOREPEAT_EN
                        rep_cnt   <= '0;
                        rep_first <= 1'b1;
`endif
                    end else begin
                        deb_cnt <= deb_cnt + 1'b1;
                    end
                end
                HELD: begin
                    if (!btn_sync) begin
                        state   <= DEB_RELEASE;
                        deb_cnt <= '0;
                    end
                end
                DEB_RELEASE: begin
                    if (btn_sync) begin
                        state   <= HELD;
                        deb_cnt <= '0;
                    end else if (deb_cnt == DEB_LAST) begin
                        // Release wins over a coincident repeat so the strobes never overlap.
                        state       <= IDLE;
                        btn_level   <= 1'b0;
                        btn_release <= 1'b1;
                        btn_pulse   <= 1'b0;
                    end else begin
                        deb_cnt <= deb_cnt + 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    deb_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: doc/button_conditioner.md
BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 1000000, SHALL set the stable-level cycles needed to accept a press or release (10 ms at 100 MHz).
REQ-002 Parameter REPEAT_DELAY, default 50000000, SHALL set the cycles from an accepted press to the first auto-repeat pulse.
REQ-003 Parameter REPEAT_PERIOD, default 20000000, SHALL set the cycles between subsequent auto-repeat pulses.
REQ-004 clk  input  1  system clock (100 MHz board clock); all state SHALL be clocked on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 btn_in  input  1  raw, asynchronous, bouncing push-button or switch level.
REQ-007 btn_level  output  1  debounced button level.
REQ-008 btn_pulse  output  1  one-clk press strobe; consumed as next_instruction, isexternal, IM_we or RF_external_load by the control unit.
REQ-009 btn_release  output  1  one-clk strobe on accepted release.

Function
REQ-010 btn_in SHALL pass through a two-flop synchronizer; only the second-flop output (btn_sync) SHALL drive the FSM.
REQ-011 FSM states SHALL be IDLE, DEB_PRESS, HELD and DEB_RELEASE.
REQ-012 IDLE: btn_sync=1 SHALL move to DEB_PRESS with the debounce counter cleared to 0.
REQ-013 DEB_PRESS: the counter SHALL increment each cycle btn_sync=1; btn_sync=0 SHALL return to IDLE and clear the counter.
REQ-014 DEB_PRESS: when the counter equals DEBOUNCE_CYCLES-1 and btn_sync=1, the FSM SHALL enter HELD, set btn_level=1 and assert btn_pulse for exactly one cycle.
REQ-015 HELD: btn_sync=0 SHALL move to DEB_RELEASE with the counter cleared.
REQ-016 DEB_RELEASE: btn_sync=1 SHALL return to HELD with no pulse; DEBOUNCE_CYCLES consecutive btn_sync=0 cycles SHALL enter IDLE, clear btn_level and assert btn_release for one cycle.
REQ-017 All outputs SHALL be registered. btn_pulse SHALL rise exactly DEBOUNCE_CYCLES+3 rising edges after the first edge that samples btn_in stably high.
REQ-018 btn_pulse and btn_release SHALL never assert in the same cycle; each accepted press SHALL yield exactly one non-repeat btn_pulse.
REQ-019 The counter width SHALL be $clog2(max of all cycle parameters)+1. The counter SHALL never wrap; it SHALL hold at its terminal value until the state changes.
REQ-020 DEBOUNCE_CYCLES below 2 SHALL raise an elaboration-time error.

Reset
REQ-021 reset=0 SHALL, asynchronously, force state IDLE, all counters to 0, both synchronizer flops to 0, and btn_level, btn_pulse and btn_release to 0.
REQ-022 Reset asserted mid-debounce or in HELD SHALL discard the press. After release, a button still held SHALL need a full DEBOUNCE_CYCLES to produce a fresh btn_pulse.

Configuration
REQ-023 With BTN_AUTOREPEAT_EN defined, HELD SHALL run a repeat counter that asserts btn_pulse for one cycle REPEAT_DELAY cycles after entry, then every REPEAT_PERIOD cycles while in HELD or DEB_RELEASE.
REQ-024 The repeat counter SHALL clear on entry to HELD from DEB_PRESS only, not on a bounce return from DEB_RELEASE.
REQ-025 Without BTN_AUTOREPEAT_EN, the repeat counter and its logic SHALL be absent, and HELD SHALL produce no further pulses.

Structure
REQ-026 Package btn_pkg SHALL hold typedef enum btn_state_t and the default constants DEBOUNCE_CYCLES_DEF, REPEAT_DELAY_DEF and REPEAT_PERIOD_DEF.
REQ-027 The synchronizer SHALL be a separate sub-module, sync_2ff, with the same clk and reset ports.

Verification (bench parameters DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3)
REQ-028 Clean press: btn_in 0->1 held 20 cycles -> single btn_pulse at edge 7 after the rise, and btn_level=1 from that edge.
REQ-029 Bounce: btn_in toggles 1,0,1,0 on successive cycles, then holds 1 -> no pulse during the toggles, and one btn_pulse 7 edges after the final rise.
REQ-030 Release glitch: while in HELD, btn_in=0 for 2 cycles then 1 -> btn_level stays 1, and no btn_release or btn_pulse occurs.
REQ-031 Reset mid-debounce: reset=0 for 1 cycle at count 2 with btn_in held 1 -> all outputs 0 immediately, and btn_pulse 7 edges after reset release.
REQ-032 Auto-repeat (macro defined): btn_in held 30 cycles -> pulses at the press, +10, +13, +16 and so on. With the macro undefined, the same stimulus SHALL produce exactly one pulse.
